// File: rtl/matrix_row_streamer_pkg.sv
// Shared types and defaults for the matrix row streamer.
package matrix_streamer_pkg;

    localparam int INDEX_WIDTH = 32;

    localparam int DEFAULT_LAYER_COUNT = 4;
    localparam int DEFAULT_ROW_COUNT   = 16;
    localparam int DEFAULT_COL_COUNT   = 3;
    localparam int DEFAULT_WORD_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } stream_state_t;

endpackage

// File: rtl/matrix_row_streamer_if.sv
// Row stream channel: the streamer drives rows as master, the consumer answers with out_ready.
interface matrix_row_streamer_if #(
    parameter int DATA_WIDTH = matrix_streamer_pkg::DEFAULT_COL_COUNT * matrix_streamer_pkg::DEFAULT_WORD_WIDTH
);
    logic                                      out_valid;
    logic [DATA_WIDTH-1:0]                     out_data;
    logic [matrix_streamer_pkg::INDEX_WIDTH-1:0] out_row_index;
    logic                                      out_last;
    logic                                      out_ready;

    modport master (
        output out_valid,
        output out_data,
        output out_row_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_storage_ram.sv
// 1R1W synchronous RAM; a read colliding with a write returns the old word.
module matrix_storage_ram #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 48,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read and write share one block so a same-address read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we && (waddr < DEPTH_LIMIT)) begin
            mem[waddr[IDX_WIDTH-1:0]] <= wdata;
        end
        if (re && (raddr < DEPTH_LIMIT)) begin
            rdata <= mem[raddr[IDX_WIDTH-1:0]];
        end
    end
endmodule

// File: rtl/matrix_row_streamer.sv
// Streams the rows of one stored layer over a valid/ready channel.
// Optional MATRIX_STREAMER_REVERSE_EN adds stream_reverse for descending row order.
module matrix_row_streamer
    import matrix_streamer_pkg::*;
#(
    parameter int LAYER_COUNT = DEFAULT_LAYER_COUNT,
    parameter int ROW_COUNT   = DEFAULT_ROW_COUNT,
    parameter int COL_COUNT   = DEFAULT_COL_COUNT,
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            is_write,
    input  logic [INDEX_WIDTH-1:0]          write_layer_index,
    input  logic [INDEX_WIDTH-1:0]          write_row_index,
    input  logic [COL_COUNT*WORD_WIDTH-1:0] write_data,
    input  logic                            stream_start,
    input  logic [INDEX_WIDTH-1:0]          stream_layer_index,
`ifdef MATRIX_STREAMER_REVERSE_EN
    input  logic                            stream_reverse,
`endif
    input  logic                            locator_reset,
    matrix_row_streamer_if.master           stream,
    output logic                            busy,
    output logic                            error
);
    localparam int DATA_WIDTH = COL_COUNT * WORD_WIDTH;
    localparam int DEPTH      = LAYER_COUNT * ROW_COUNT;
    localparam logic [INDEX_WIDTH-1:0] LAYERS   = INDEX_WIDTH'(LAYER_COUNT);
    localparam logic [INDEX_WIDTH-1:0] ROWS     = INDEX_WIDTH'(ROW_COUNT);
    localparam logic [INDEX_WIDTH-1:0] LAST_ROW = ROWS - INDEX_WIDTH'(1);

    stream_state_t          state;
    logic [INDEX_WIDTH-1:0] layer_q;
    logic [INDEX_WIDTH-1:0] row_q;
    logic [INDEX_WIDTH-1:0] out_row_q;
    logic                   reverse_q;
    logic                   valid_q;
    logic                   last_q;
    logic [DATA_WIDTH-1:0]  rd_data;

    logic                   write_ok;
    logic                   start_req;
    logic                   start_in_range;
    logic                   start_reverse;
    logic                   row_is_last;
    logic [INDEX_WIDTH-1:0] row_next;
    logic [INDEX_WIDTH-1:0] waddr;
    logic [INDEX_WIDTH-1:0] raddr;

`ifdef MATRIX_STREAMER_REVERSE_EN
    assign start_reverse = stream_reverse;
`else
    assign start_reverse = 1'b0;
`endif

    assign write_ok       = is_write && (write_layer_index < LAYERS) && (write_row_index < ROWS);
    assign waddr          = write_layer_index * ROWS + write_row_index;
    assign raddr          = layer_q * ROWS + row_q;
    assign start_req      = stream_start && !locator_reset && (state == IDLE);
    assign start_in_range = stream_layer_index < LAYERS;
    assign row_is_last    = reverse_q ? (row_q == '0) : (row_q == LAST_ROW);
    assign row_next       = reverse_q ? (row_q - INDEX_WIDTH'(1)) : (row_q + INDEX_WIDTH'(1));

    matrix_storage_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (INDEX_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (write_ok),
        .waddr (waddr),
        .wdata (write_data),
        .re    (state == FETCH),
        .raddr (raddr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            layer_q   <= '0;
            row_q     <= '0;
            out_row_q <= '0;
            reverse_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            error <= (is_write && !write_ok) || (start_req && !start_in_range);
            if (locator_reset) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_req && start_in_range) begin
                            layer_q   <= stream_layer_index;
                            reverse_q <= start_reverse;
                            row_q     <= start_reverse ? LAST_ROW : '0;
                            state     <= FETCH;
                            busy      <= 1'b1;
                        end
                    end
                    FETCH: begin
                        state     <= PRESENT;
                        valid_q   <= 1'b1;
                        last_q    <= row_is_last;
                        out_row_q <= row_q;
                    end
                    PRESENT: begin
                        if (stream.out_ready) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (last_q) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                row_q <= row_next;
                                state <= FETCH;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // RAM read register holds its word until the next FETCH, so gating by valid keeps data stable and zero at reset.
    assign stream.out_valid     = valid_q;
    assign stream.out_last      = last_q;
    assign stream.out_row_index = out_row_q;
    assign stream.out_data      = valid_q ? rd_data : '0;
endmodule

// File: tb/tb_matrix_row_streamer.sv
// Directed bench for matrix_row_streamer with a row-level reference model and per-cycle stream monitor.
module tb_matrix_row_streamer;
    localparam int L  = 2;
    localparam int R  = 4;
    localparam int C  = 3;
    localparam int W  = 16;
    localparam int DW = C * W;

    typedef struct {
        logic [DW-1:0] data;
        int            row;
        bit            last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          is_write;
    logic [31:0]   write_layer_index;
    logic [31:0]   write_row_index;
    logic [DW-1:0] write_data;
    logic          stream_start;
    logic [31:0]   stream_layer_index;
    logic          locator_reset;
    logic          busy;
    logic          error;
`ifdef MATRIX_STREAMER_REVERSE_EN
    logic          stream_reverse;
`endif

    matrix_row_streamer_if #(.DATA_WIDTH(DW)) sif ();

    matrix_row_streamer #(
        .LAYER_COUNT (L),
        .ROW_COUNT   (R),
        .COL_COUNT   (C),
        .WORD_WIDTH  (W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .is_write           (is_write),
        .write_layer_index  (write_layer_index),
        .write_row_index    (write_row_index),
        .write_data         (write_data),
        .stream_start       (stream_start),
        .stream_layer_index (stream_layer_index),
`ifdef MATRIX_STREAMER_REVERSE_EN
        .stream_reverse     (stream_reverse),
`endif
        .locator_reset      (locator_reset),
        .stream             (sif),
        .busy               (busy),
        .error              (error)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    int            hs_count = 0;
    bit            prev_hs = 1'b0;
    logic [DW-1:0] mem_m [L][R];
    beat_t         exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented beat must match the model queue head; a handshake pops it.
    always @(negedge clk) begin
        if (prev_hs) check("row_gap", sif.out_valid, 1'b0);
        if (sif.out_valid) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("beat_data", sif.out_data, exp_q[0].data);
                check("beat_row", sif.out_row_index, exp_q[0].row);
                check("beat_last", sif.out_last, exp_q[0].last);
                if (sif.out_ready) void'(exp_q.pop_front());
            end
        end
        prev_hs = sif.out_valid && sif.out_ready;
        if (prev_hs) hs_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int layer, input int row, input logic [DW-1:0] data);
        is_write          = 1'b1;
        write_layer_index = layer;
        write_row_index   = row;
        write_data        = data;
        tick();
        is_write = 1'b0;
        if (layer < L && row < R) mem_m[layer][row] = data;
    endtask

    task automatic start_stream(input int layer, input bit rev);
        stream_start       = 1'b1;
        stream_layer_index = layer;
`ifdef MATRIX_STREAMER_REVERSE_EN
        stream_reverse     = rev;
`endif
        tick();
        stream_start = 1'b0;
        if (layer < L) begin
            for (int k = 0; k < R; k++) begin
                int r;
                r = rev ? (R - 1 - k) : k;
                exp_q.push_back('{mem_m[layer][r], r, (k == R - 1)});
            end
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            tick();
        end
        check({name, "_idle"}, busy, 1'b0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_row(input string name, input int row);
        for (int i = 0; i < 40; i++) begin
            if (sif.out_valid && sif.out_row_index == row) break;
            tick();
        end
        check(name, sif.out_valid && (sif.out_row_index == row), 1'b1);
    endtask

    initial begin
        int hs_before;
        reset              = 1'b1;
        is_write           = 1'b0;
        write_layer_index  = '0;
        write_row_index    = '0;
        write_data         = '0;
        stream_start       = 1'b0;
        stream_layer_index = '0;
        locator_reset      = 1'b0;
        sif.out_ready      = 1'b0;
`ifdef MATRIX_STREAMER_REVERSE_EN
        stream_reverse     = 1'b0;
`endif
        tick();
        tick();
        check("rst_valid", sif.out_valid, 1'b0);
        check("rst_last", sif.out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_data", sif.out_data, 0);
        check("rst_row", sif.out_row_index, 0);
        reset = 1'b0;
        tick();

        for (int r = 0; r < R; r++) begin
            write_row(1, r, 48'h0001_0002_0003 + 48'(r));
            write_row(0, r, 48'h00A0_00B0_0000 + 48'(r));
        end

        // Free-flowing stream of layer 1
        sif.out_ready = 1'b1;
        hs_before = hs_count;
        start_stream(1, 1'b0);
        check("fetch_no_valid", sif.out_valid, 1'b0);
        check("fetch_busy", busy, 1'b1);
        tick();
        check("first_valid", sif.out_valid, 1'b1);
        check("first_data", sif.out_data, 48'h0001_0002_0003);
        check("first_row", sif.out_row_index, 0);
        wait_idle("stream1");
        check("stream1_beats", hs_count - hs_before, 4);

        // Stall at row 2 for five cycles
        hs_before = hs_count;
        start_stream(1, 1'b0);
        wait_row("stall_reach", 2);
        sif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", sif.out_valid, 1'b1);
            check("stall_data", sif.out_data, 48'h0001_0002_0005);
            check("stall_row", sif.out_row_index, 2);
        end
        sif.out_ready = 1'b1;
        wait_idle("stall");
        check("stall_beats", hs_count - hs_before, 4);

        // Rejected requests
        write_row(2, 0, 48'hDEAD_BEEF_0000);
        check("wr_layer_err", error, 1'b1);
        check("wr_layer_busy", busy, 1'b0);
        tick();
        check("wr_layer_err_end", error, 1'b0);
        write_row(0, 4, 48'hDEAD_BEEF_0001);
        check("wr_row_err", error, 1'b1);
        tick();
        check("wr_row_err_end", error, 1'b0);
        start_stream(7, 1'b0);
        check("start_err", error, 1'b1);
        check("start_err_busy", busy, 1'b0);
        tick();
        check("start_err_end", error, 1'b0);
        check("start_err_busy2", busy, 1'b0);
        hs_before = hs_count;
        start_stream(0, 1'b0);
        tick();
        check("l0_first_data", sif.out_data, 48'h00A0_00B0_0000);
        wait_idle("layer0");
        start_stream(1, 1'b0);
        wait_idle("layer1_again");
        check("ram_intact_beats", hs_count - hs_before, 8);

        // locator_reset wins over a simultaneous stream_start
        stream_start       = 1'b1;
        stream_layer_index = 1;
        locator_reset      = 1'b1;
        tick();
        stream_start  = 1'b0;
        locator_reset = 1'b0;
        check("prio_busy", busy, 1'b0);
        check("prio_error", error, 1'b0);
        tick();
        check("prio_busy2", busy, 1'b0);

        // locator_reset while row 1 is presented, then restart
        start_stream(1, 1'b0);
        wait_row("abort_reach", 1);
        sif.out_ready = 1'b0;
        locator_reset = 1'b1;
        tick();
        locator_reset = 1'b0;
        check("abort_valid", sif.out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        exp_q.delete();
        sif.out_ready = 1'b1;
        hs_before = hs_count;
        start_stream(1, 1'b0);
        tick();
        check("restart_row", sif.out_row_index, 0);
        wait_idle("restart");
        check("restart_beats", hs_count - hs_before, 4);

        // Asynchronous reset between edges mid-stream
        start_stream(1, 1'b0);
        wait_row("areset_reach", 1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", sif.out_valid, 1'b0);
        check("areset_data", sif.out_data, 0);
        check("areset_row", sif.out_row_index, 0);
        check("areset_last", sif.out_last, 1'b0);
        check("areset_busy", busy, 1'b0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        hs_before = hs_count;
        for (int i = 0; i < 6; i++) tick();
        check("areset_no_beats", hs_count - hs_before, 0);
        check("areset_still_idle", busy, 1'b0);

`ifdef MATRIX_STREAMER_REVERSE_EN
        hs_before = hs_count;
        start_stream(1, 1'b1);
        tick();
        check("rev_first_row", sif.out_row_index, 3);
        check("rev_first_data", sif.out_data, 48'h0001_0002_0006);
        wait_idle("reverse");
        check("rev_beats", hs_count - hs_before, 4);
        start_stream(1, 1'b0);
        wait_idle("forward_after_rev");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/matrix_row_streamer.md
MATRIX_ROW_STREAMER -- requirements
Module: matrix_row_streamer

Interface
REQ-001 SHALL have parameter LAYER_COUNT, default 4, number of stored layers.
REQ-002 SHALL have parameter ROW_COUNT, default 16, rows per layer.
REQ-003 SHALL have parameter COL_COUNT, default 3, words per row.
REQ-004 SHALL have parameter WORD_WIDTH, default 16, fixed-point word width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port is_write, input, 1 bit: write strobe.
REQ-008 SHALL have ports write_layer_index and write_row_index, input, 32 bits each: write address.
REQ-009 SHALL have port write_data, input, COL_COUNT*WORD_WIDTH bits: row payload, with column 0 in the LSBs.
REQ-010 SHALL have port stream_start, input, 1 bit: request to stream one layer.
REQ-011 SHALL have port stream_layer_index, input, 32 bits: the layer to stream.
REQ-012 SHALL have port locator_reset, input, 1 bit: synchronous stream abort.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer ready.
REQ-014 SHALL have ports out_valid (1), out_data (COL_COUNT*WORD_WIDTH), out_row_index (32) and out_last (1), all outputs.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 SHALL have port error, output, 1 bit: one-cycle pulse flagging a rejected request.

Function
REQ-017 SHALL store LAYER_COUNT*ROW_COUNT rows in a RAM with one synchronous read port and one write port.
REQ-018 SHALL write a row on the cycle is_write=1 when layer < LAYER_COUNT and row < ROW_COUNT.
REQ-019 SHALL ignore an out-of-range write and pulse error for one cycle.
REQ-020 SHALL return the pre-write (old) data when a read and a write hit the same address in the same cycle.
REQ-021 SHALL implement the states IDLE, FETCH and PRESENT.
REQ-022 SHALL, in IDLE, on stream_start with an in-range layer, latch the layer, set the row counter to 0 and enter FETCH.
REQ-023 SHALL, in IDLE, on stream_start with an out-of-range layer, stay in IDLE and pulse error.
REQ-024 SHALL ignore stream_start in FETCH or PRESENT without asserting error.
REQ-025 SHALL, in FETCH, issue the RAM read and enter PRESENT on the next cycle.
REQ-026 SHALL assert out_valid, out_data and out_row_index in PRESENT and hold them stable until out_valid && out_ready.
REQ-027 SHALL assert out_last only while presenting the final row of the layer.
REQ-028 SHALL, on a PRESENT handshake, return to IDLE if out_last is high, else advance the row counter and enter FETCH.
REQ-029 SHALL deliver at most one row every 2 cycles.
REQ-030 SHALL make the first out_valid appear 2 cycles after an accepted stream_start.
REQ-031 SHALL, on locator_reset, enter IDLE on the next edge and drop out_valid; locator_reset takes priority over stream_start.
REQ-032 SHALL leave RAM contents unchanged on locator_reset.
REQ-033 SHALL perform writes during streaming, and a streamed row reflects RAM contents at its FETCH cycle.

Reset
REQ-034 SHALL, on reset, force state IDLE and clear the row counter.
REQ-035 SHALL, on reset, drive out_valid, out_last, busy and error to 0, and out_data and out_row_index to 0.
REQ-036 SHALL leave RAM contents undefined after reset.
REQ-037 SHALL abort any stream in progress when reset asserts mid-stream, with no further handshakes until a new stream_start.

Configuration
REQ-038 SHALL, with MATRIX_STREAMER_REVERSE_EN defined, add input stream_reverse (1 bit), sampled with stream_start.
REQ-039 SHALL, when stream_reverse was 1, stream rows ROW_COUNT-1 down to 0, with out_last on row 0.
REQ-040 SHALL, without MATRIX_STREAMER_REVERSE_EN, omit the stream_reverse port and always stream in ascending row order.

Structure
REQ-041 SHALL place the state enum, the INDEX_WIDTH=32 constant and the default parameter values in package matrix_streamer_pkg.
REQ-042 SHALL instantiate sub-module matrix_storage_ram (parametrised 1R1W synchronous RAM); all FSM logic stays in the top module.

Verification (LAYER_COUNT=2, ROW_COUNT=4, COL_COUNT=3, WORD_WIDTH=16)
REQ-043 SHALL cover: write rows 0-3 of layer 1 with 48'h0001_0002_0003+row, start layer 1 with out_ready=1 -> 4 beats, rows 0..3, correct data, out_last on row 3, busy low after.
REQ-044 SHALL cover: the same stream with out_ready low for 5 cycles at row 2 -> out_data and out_row_index held constant, no row lost or duplicated.
REQ-045 SHALL cover: write to layer 2 and start layer 7 -> error pulses exactly 1 cycle each, RAM unchanged, busy stays 0.
REQ-046 SHALL cover: locator_reset while row 1 is presented -> out_valid=0 next cycle, state IDLE; a restart streams from row 0.
REQ-047 SHALL cover: async reset asserted between clock edges mid-stream -> outputs 0 immediately; with REVERSE_EN and stream_reverse=1 -> rows 3,2,1,0 with out_last on row 0.
